// File: rtl/exec_regfile_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exec_regfile_unit_pkg
//  Purpose  : Shared constants for the execute-stage register file unit:
//             default data width, register address width and the ALU
//             operation codes understood by exec_regfile_unit.
//  Revision : 1.0 - initial release
// ============================================================================
package exec_regfile_unit_pkg;

  // Default datapath width and register address width (32 registers).
  localparam int PKG_XLEN   = 32;
  localparam int PKG_REG_AW = 5;

  // ALU operation encoding; codes 11..15 are unassigned and yield zero.
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

endpackage : exec_regfile_unit_pkg
`default_nettype wire

// File: rtl/exec_regfile_unit_rf_array.sv
`default_nettype none
// ============================================================================
//  Module   : rf_array
//  Purpose  : Architectural register array with two asynchronous read ports
//             and one synchronous write port. Register 0 is hard-wired to
//             zero. All storage clears asynchronously while rst_n is low.
//  Ports    : clk            - write clock (rising edge)
//             rst_n          - asynchronous active-low clear
//             wen/waddr/wdata- write port
//             raddr1/raddr2  - read addresses
//             rdata1/rdata2  - combinational read data (no write bypass)
//  Revision : 1.0 - initial release
// ============================================================================
module rf_array #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  // Flattened view of every register, entry 0 being the constant zero.
  logic [XLEN-1:0] rd_bus [NREGS];

  assign rd_bus[0] = '0;

  // One storage word per writable register; index 0 has no storage so a
  // write aimed at it simply matches nothing and is dropped.
  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [XLEN-1:0] reg_d;
    logic [XLEN-1:0] reg_q;

    always_comb begin
      reg_d = reg_q;
      if (wen && (waddr == AW'(i))) begin
        reg_d = wdata;
      end
    end

    // While rst_n is low the clear term dominates, so a write presented on
    // the same edge is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rd_bus[i] = reg_q;
  end

  // Reads see the registered value only: a same-cycle write becomes visible
  // after the edge, and two ports on one address see the same word.
  assign rdata1 = rd_bus[raddr1];
  assign rdata2 = rd_bus[raddr2];

endmodule : rf_array
`default_nettype wire

// File: rtl/exec_regfile_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exec_regfile_unit
//  Purpose  : Execute-stage slice: register file (rf_array), a purely
//             combinational ALU and a one-hot funct3 decoder.
//  Ports    : clk, reset      - clock, asynchronous active-low reset
//             wen/waddr/wdata - register write port
//             raddr1/raddr2   - read addresses, rdata1/rdata2 read data
//             alu_src1/2      - ALU operands, alu_op select, alu_result
//             funct3          - field in, funct3_d one-hot decode out
//  Revision : 1.0 - initial release
// ============================================================================
module exec_regfile_unit #(
  parameter int  XLEN  = exec_regfile_unit_pkg::PKG_XLEN,
  parameter int  NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_result,
  input  logic [2:0]      funct3,
  output logic [7:0]      funct3_d
);

  import exec_regfile_unit_pkg::*;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  rf_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf_array (
    .clk    (clk),
    .rst_n  (reset),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // --------------------------------------------------------------------------
  // ALU: zero latency, independent of reset. Only the low five bits of
  // src2 form the shift amount; add/sub wrap with no carry out.
  // --------------------------------------------------------------------------
  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = alu_src2[4:0];
  assign lt_signed   = $signed(alu_src1) < $signed(alu_src2);
  assign lt_unsigned = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:    alu_result = alu_src1 + alu_src2;
      ALU_SUB:    alu_result = alu_src1 - alu_src2;
      ALU_AND:    alu_result = alu_src1 & alu_src2;
      ALU_OR:     alu_result = alu_src1 | alu_src2;
      ALU_XOR:    alu_result = alu_src1 ^ alu_src2;
      ALU_SLL:    alu_result = alu_src1 << shamt;
      ALU_SRL:    alu_result = alu_src1 >> shamt;
      ALU_SRA:    alu_result = XLEN'($signed(alu_src1) >>> shamt);
      ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_PASS_B: alu_result = alu_src2;
      default:    alu_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // funct3 one-hot decoder; a 3-bit field always sets exactly one of 8 bits.
  // --------------------------------------------------------------------------
  assign funct3_d = 8'd1 << funct3;

endmodule : exec_regfile_unit
`default_nettype wire

// File: tb/tb_exec_regfile_unit.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_exec_regfile_unit
//  Purpose  : Self-checking bench for exec_regfile_unit: directed checks on
//             reset, x0, read-before-write, ALU corner cases and decoder,
//             plus randomized register/ALU traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_regfile_unit;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int n_cmp;
  int n_err;

  // Reference register contents.
  logic [31:0] mregs [32];

  exec_regfile_unit dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_d   (funct3_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    int     sh;
    logic [31:0] r;
    ua = a;
    ub = b;
    sa = ua - (a[31] ? 64'sd4294967296 : 64'sd0);
    sb = ub - (b[31] ? 64'sd4294967296 : 64'sd0);
    sh = int'(b[4:0]);
    r  = 32'd0;
    case (op)
      4'd0:  r = 32'(ua + ub);
      4'd1:  r = 32'(ua - ub);
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = 32'(ua * (64'd1 << sh));
      4'd6:  r = 32'(ua / (64'd1 << sh));
      4'd7:  r = a[31] ? ~32'((~ua & 64'hFFFF_FFFF) / (64'd1 << sh))
                       : 32'(ua / (64'd1 << sh));
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  // Reset asserted with no clock edge: every address reads 0; then a write
  // to x0 after release is dropped.
  task automatic test_reset();
    #1 reset = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #0.1;
      n_cmp++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read addr=%0d: got %h/%h expected 0", i, rdata1, rdata2);
      end
    end
    reset  = 1'b1;
    wen    = 1'b1;
    waddr  = 5'd0;
    wdata  = 32'hDEADBEEF;
    raddr1 = 5'd0;
    @(posedge clk); #1;
    n_cmp++;
    if (rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL x0_write: got %h expected 00000000", rdata1);
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Write to x5: old value before the edge, new value after it.
  task automatic test_write_rbw();
    @(negedge clk);
    wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_cmp++;
    if (rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL rbw_before: got %h expected 00000000", rdata1);
    end
    @(posedge clk); #1;
    mregs[5] = 32'h12345678;
    n_cmp++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      n_err++;
      $display("FAIL rbw_after: got %h/%h expected 12345678", rdata1, rdata2);
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Fill registers, assert reset between edges, check immediate clear,
  // write blocked during reset, and first edge after release accepted.
  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wen = 1'b1; waddr = 5'(i); wdata = $urandom | 32'h1;
      @(posedge clk);
      mregs[i] = wdata;
    end
    @(negedge clk);
    wen = 1'b0; raddr1 = 5'd5;
    #1;
    n_cmp++;
    if (rdata1 !== mregs[5]) begin
      n_err++;
      $display("FAIL fill_x5: got %h expected %h", rdata1, mregs[5]);
    end
    #1;
    wen = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_AAAA;
    reset = 1'b0;
    model_clear();
    #0.5;
    n_cmp++;
    if (rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL async_clear_x5: got %h expected 00000000", rdata1);
    end
    for (int i = 0; i < 32; i++) begin
      raddr2 = 5'(i);
      #0.1;
      n_cmp++;
      if (rdata2 !== 32'd0) begin
        n_err++;
        $display("FAIL async_clear addr=%0d: got %h expected 0", i, rdata2);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL write_in_reset: got %h expected 00000000", rdata1);
    end
    @(negedge clk);
    reset = 1'b1;
    wdata = 32'h0000_0055;
    @(posedge clk); #1;
    mregs[5] = 32'h0000_0055;
    n_cmp++;
    if (rdata1 !== 32'h0000_0055) begin
      n_err++;
      $display("FAIL first_write_after_release: got %h expected 00000055", rdata1);
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Directed ALU corner cases: wrap, signed/unsigned compare, shifts,
  // undefined code, PASS_B.
  task automatic test_alu_directed();
    logic [3:0]  ops [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    logic [31:0] exp [9];
    ops = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd7, 4'd6, 4'd5, 4'd13, 4'd10};
    as  = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h80000000, 32'h80000000,
            32'h80000000, 32'h1, 32'h12345678, 32'h11111111};
    bs  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h4, 32'h21, 32'h9ABCDEF0, 32'hCAFEF00D};
    exp = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h08000000,
            32'h2, 32'h0, 32'hCAFEF00D};
    for (int i = 0; i < 9; i++) begin
      alu_op = ops[i]; alu_src1 = as[i]; alu_src2 = bs[i];
      #1;
      n_cmp++;
      if (alu_result !== exp[i]) begin
        n_err++;
        $display("FAIL alu_directed op=%0d: got %h expected %h", ops[i], alu_result, exp[i]);
      end
    end
  endtask

  task automatic test_decoder();
    logic [7:0] expv;
    for (int i = 0; i < 8; i++) begin
      funct3 = 3'(i);
      expv = 8'(2 ** i);
      #1;
      n_cmp++;
      if (funct3_d !== expv || $countones(funct3_d) != 1) begin
        n_err++;
        $display("FAIL decoder funct3=%0d: got %h expected %h", i, funct3_d, expv);
      end
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      alu_op   = 4'($urandom_range(0, 15));
      alu_src1 = (i % 7 == 0) ? 32'h80000000 : $urandom;
      alu_src2 = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      e = alu_ref(alu_op, alu_src1, alu_src2);
      #1;
      n_cmp++;
      if (alu_result !== e) begin
        n_err++;
        $display("FAIL alu_random op=%0d a=%h b=%h: got %h expected %h",
                 alu_op, alu_src1, alu_src2, alu_result, e);
      end
    end
  endtask

  // Random writes and reads with concurrent ALU activity every cycle.
  task automatic test_back_to_back();
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wen    = 1'($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = (i % 4 == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = (i % 3 == 0) ? raddr1 : 5'($urandom_range(0, 31));
      alu_op   = 4'($urandom_range(0, 10));
      alu_src1 = $urandom;
      alu_src2 = $urandom;
      e = alu_ref(alu_op, alu_src1, alu_src2);
      #1;
      n_cmp++;
      if (rdata1 !== mregs[raddr1] || rdata2 !== mregs[raddr2]) begin
        n_err++;
        $display("FAIL b2b_pre_edge a1=%0d a2=%0d: got %h/%h expected %h/%h",
                 raddr1, raddr2, rdata1, rdata2, mregs[raddr1], mregs[raddr2]);
      end
      @(posedge clk);
      if (wen && waddr != 5'd0) mregs[waddr] = wdata;
      #1;
      n_cmp++;
      if (rdata1 !== mregs[raddr1] || rdata2 !== mregs[raddr2] || alu_result !== e) begin
        n_err++;
        $display("FAIL b2b_post_edge a1=%0d a2=%0d: got %h/%h alu %h expected %h/%h alu %h",
                 raddr1, raddr2, rdata1, rdata2, alu_result,
                 mregs[raddr1], mregs[raddr2], e);
      end
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; wen = 1'b0; waddr = 5'd0; wdata = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    alu_src1 = 32'd0; alu_src2 = 32'd0; alu_op = 4'd0; funct3 = 3'd0;
    model_clear();

    test_reset();
    test_write_rbw();
    test_async_reset();
    test_alu_directed();
    test_decoder();
    test_alu_random();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_exec_regfile_unit
`default_nettype wire
